// File: rtl/gate_seq_pkg.sv
// Shared types, constants and the truth-table helper for the gate-unit self-test sequencer.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int NUM_VEC = 4;
  localparam int VEC_W   = 2;

  // vec = {A,B}; result = {and, or, not-of-A}
  function automatic logic [2:0] expected_out(input logic [VEC_W-1:0] vec);
    logic a;
    logic b;
    a = vec[1];
    b = vec[0];
    return {a & b, a | b, ~a};
  endfunction

endpackage

// File: rtl/gate_seq_checker.sv
// Compares the three sampled gate outputs against the expected truth-table row for {A,B}.
module gate_seq_checker
  import gate_seq_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic             andIn,
  input  logic             orIn,
  input  logic             notIn,
  output logic             mismatch
);

  // Any differing bit flags the whole vector once
  always_comb begin
    mismatch = ({andIn, orIn, notIn} != expected_out(vec));
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Built-in self-test sequencer for the two-input gate unit: walks {A,B} through 00..11 and counts failing vectors.
// Optional first-failure capture (oErrVld/oErrVec) is enabled by defining GATE_SEQ_ERRCAP_EN.
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = 8
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iStart,
  input  logic       iAnd,
  input  logic       iOr,
  input  logic       iNot,
  output logic       oA,
  output logic       oB,
  output logic       oBusy,
  output logic       oDone,
  output logic       oPass,
  output logic [2:0] oErrCnt
`ifdef GATE_SEQ_ERRCAP_EN
  ,
  output logic       oErrVld,
  output logic [1:0] oErrVec
`endif
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_APPLY = APPLY;
  localparam logic [1:0] S_CHECK = CHECK;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(NUM_VEC - 1);

  logic [1:0]        stateR;
  logic [VEC_W-1:0]  vecIdxR;
  logic [HOLD_W-1:0] holdCntR;
  logic              mismatchS;
  logic [2:0]        errCntNextS;

  gate_seq_checker uChecker (
    .vec      (vecIdxR),
    .andIn    (iAnd),
    .orIn     (iOr),
    .notIn    (iNot),
    .mismatch (mismatchS)
  );

  // At most four vectors can fail, so a 3-bit counter never wraps
  always_comb begin
    errCntNextS = oErrCnt + {2'b00, mismatchS};
  end

  // Sequencer FSM, vector/hold counters and registered outputs
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      stateR   <= S_IDLE;
      vecIdxR  <= 2'd0;
      holdCntR <= '0;
      oA       <= 1'b0;
      oB       <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oPass    <= 1'b0;
      oErrCnt  <= 3'd0;
`ifdef GATE_SEQ_ERRCAP_EN
      oErrVld  <= 1'b0;
      oErrVec  <= 2'd0;
`endif
    end else begin
      case (stateR)
        S_IDLE, S_DONE: begin
          if (iStart) begin
            stateR   <= S_APPLY;
            vecIdxR  <= 2'd0;
            holdCntR <= '0;
            oA       <= 1'b0;
            oB       <= 1'b0;
            oBusy    <= 1'b1;
            oDone    <= 1'b0;
            oPass    <= 1'b0;
            oErrCnt  <= 3'd0;
`ifdef GATE_SEQ_ERRCAP_EN
            oErrVld  <= 1'b0;
            oErrVec  <= 2'd0;
`endif
          end
        end
        S_APPLY: begin
          if (holdCntR == HOLD_LAST) begin
            stateR <= S_CHECK;
          end else begin
            holdCntR <= holdCntR + HOLD_W'(1);
          end
        end
        S_CHECK: begin
          oErrCnt <= errCntNextS;
`ifdef GATE_SEQ_ERRCAP_EN
          // Only the first failing vector of a run is kept
          if (mismatchS && !oErrVld) begin
            oErrVld <= 1'b1;
            oErrVec <= vecIdxR;
          end
`endif
          if (vecIdxR == VEC_LAST) begin
            stateR <= S_DONE;
            oA     <= 1'b0;
            oB     <= 1'b0;
            oBusy  <= 1'b0;
            oDone  <= 1'b1;
            oPass  <= (errCntNextS == 3'd0);
          end else begin
            stateR   <= S_APPLY;
            vecIdxR  <= vecIdxR + 2'd1;
            holdCntR <= '0;
            {oA, oB} <= vecIdxR + 2'd1;
          end
        end
        default: begin
          stateR <= S_IDLE;
        end
      endcase
    end
  end

endmodule
